mac_dispatch: RTL
=================

# mac_dispatch

Operand dispatcher that converts one interleaved HWPE-Stream of 32-bit words from a TCDM streamer into the three operand streams consumed by the MAC engine. It emits c (the accumulator init word) and then len aligned a/b pairs. It drives the engine's sink ports, which requires a and b to be presented valid together, and it holds data stable under backpressure. Per-job control comes from the controller FSM through a packed control struct; state goes back through a packed flags struct.

## Interface
- DATA_WIDTH, 32: width of in_i, a_o, b_o, c_o data.
- CNT_WIDTH, $clog2(MAC_CNT_LEN)+1: width of len and the pair counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- test_mode_i  in  1  unused, reserved
- in_i  hwpe_stream sink  DATA_WIDTH  interleaved word stream (strb ignored)
- a_o  hwpe_stream source  DATA_WIDTH  operand a; strb '1
- b_o  hwpe_stream source  DATA_WIDTH  operand b; strb '1
- c_o  hwpe_stream source  DATA_WIDTH  accumulator init; strb '1
- ctrl_i  in  ctrl_dispatch_t  fields: start, clear, enable, simple_mul, len[CNT_WIDTH]
- flags_o  out  flags_dispatch_t  fields: state, cnt[CNT_WIDTH], done, stall_cnt[16]

## Operation
- Registers:
  - r_c: c output register, with valid.
  - r_a: a-hold register.
  - r_pair: a/b output register, with pair_valid.
  - r_cnt, r_len, r_mode, state.
- States: IDLE, LOAD_C, LOAD_A, LOAD_B, DRAIN.
- IDLE, on start & enable:
  - Latch len and simple_mul.
  - Clear r_cnt.
  - Go to LOAD_C if scalar mode.
  - Otherwise go to DRAIN if len==0, else to LOAD_A.
  - start is ignored in every other state.
- LOAD_C:
  - in_i.ready = ~c_valid | c_o.ready.
  - On handshake, the word goes to r_c and c_valid is set.
  - Next state is DRAIN if len==0, else LOAD_A.
- LOAD_A:
  - in_i.ready = 1.
  - On handshake, the word goes to r_a; next state LOAD_B.
- LOAD_B:
  - in_i.ready = ~pair_valid | (a_o.ready & b_o.ready).
  - On handshake, r_pair ← {r_a, word}, pair_valid is set, and r_cnt increments.
  - Next state is DRAIN if the new cnt==len, else LOAD_A.
- DRAIN: when ~pair_valid & ~c_valid, go to IDLE and pulse done.
- Output handshake rules:
  - a_o.valid = b_o.valid = pair_valid.
  - The pair is consumed only when a_o.ready & b_o.ready in the same cycle; a single-sided ready does not consume.
  - The c handshake is independent of the pair.
  - A valid output never deasserts before its handshake.
  - Data is unchanged while valid is high and unacknowledged.
- A pair load and a pair consume in the same cycle is allowed: new data is loaded and pair_valid stays 1.
- enable=0:
  - in_i.ready=0, and state and counters are frozen.
  - Output registers are still drained by handshakes.
- clear: synchronous. It resets every register to its reset value in the next cycle, including mid-job, and no done pulse is produced.
- in_i.ready outside the LOAD states is 0.

## Timing
- Reset values:
  - All valids 0, all data 0.
  - in_i.ready 0, state IDLE.
  - flags_o all 0.
- Latency: an input word accepted in cycle N appears on c_o or a_o/b_o in cycle N+1.
- Throughput: 1 input word per cycle; 1 pair per 2 cycles at most.
- start accepted in cycle N puts state in LOAD_* or DRAIN in cycle N+1.
- done is high exactly one cycle: the first IDLE cycle after DRAIN.
- flags_o.cnt = r_cnt, registered. flags_o.state = current state.

## Configuration
- MAC_DISPATCH_STALL_CNT_EN:
  - When defined, stall_cnt is a 16-bit saturating counter of cycles where pair_valid & ~(a_o.ready & b_o.ready).
  - It is cleared by clear and by an accepted start.
  - When undefined, stall_cnt is tied to 0 and no counter logic exists.

## Structure
- mac_package:
  - ctrl_dispatch_t and flags_dispatch_t.
  - dispatch_state_t enum (IDLE, LOAD_C, LOAD_A, LOAD_B, DRAIN).
  - MAC_CNT_LEN, shared with the engine.
- No sub-module: the FSM, pair register and c register are inline.
- Stall counter logic sits under the macro.

## Test plan
- simple_mul=1, len=3, words 1..6, sinks always ready → pairs (1,2),(3,4),(5,6); no c_o valid; cnt=3; one done pulse.
- simple_mul=0, len=2, words 10,1,2,3,4 → c_o=10 one cycle after acceptance, then pairs (1,2),(3,4); done after the last pair is consumed.
- Pair valid while a_o.ready=1 and b_o.ready=0 for 5 cycles → pair stays (1,2) and not consumed; in_i.ready=0 in LOAD_B; stall_cnt=5 with the macro defined, 0 without.
- len=0, simple_mul=1 → no outputs; done one cycle after DRAIN. len=0, simple_mul=0 → only c_o emitted, then done.
- clear asserted after 1 pair is emitted (len=4) → next cycle all valids 0, state IDLE, cnt 0, no done; a following start with len=1 runs correctly.
- start pulsed in LOAD_B → ignored, len unchanged. enable=0 for 3 cycles mid-job → in_i.ready=0, state frozen, pending pair still drains.

Source files
------------

// File: rtl/mac_package.sv
// Shared MAC types: dispatcher control/flag structs, dispatcher state enum and the
// pair-count limit shared with the engine.
package mac_package;

  localparam int unsigned MAC_CNT_LEN = 1024;
  localparam int unsigned CNT_WIDTH   = $clog2(MAC_CNT_LEN) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_C = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    DRAIN  = 3'd4
  } dispatch_state_t;

  typedef struct packed {
    logic                 start;
    logic                 clear;
    logic                 enable;
    logic                 simple_mul;
    logic [CNT_WIDTH-1:0] len;
  } ctrl_dispatch_t;

  typedef struct packed {
    dispatch_state_t      state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 done;
    logic [15:0]          stall_cnt;
  } flags_dispatch_t;

endpackage

// File: rtl/mac_dispatch.sv
// Splits one interleaved word stream into c (accumulator init) and aligned a/b operand streams.
// Define MAC_DISPATCH_STALL_CNT_EN to get a saturating pair-stall counter in flags_o.stall_cnt.
module mac_dispatch
  import mac_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [DATA_WIDTH-1:0]   a_data_o,
  output logic [DATA_WIDTH/8-1:0] a_strb_o,
  output logic                    a_valid_o,
  input  logic                    a_ready_i,
  output logic [DATA_WIDTH-1:0]   b_data_o,
  output logic [DATA_WIDTH/8-1:0] b_strb_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [DATA_WIDTH-1:0]   c_data_o,
  output logic [DATA_WIDTH/8-1:0] c_strb_o,
  output logic                    c_valid_o,
  input  logic                    c_ready_i,
  input  ctrl_dispatch_t          ctrl_i,
  output flags_dispatch_t         flags_o
);

  // state  | meaning
  // IDLE   | waiting for start & enable
  // LOAD_C | accepting the accumulator init word
  // LOAD_A | accepting operand a into the hold register
  // LOAD_B | accepting operand b and loading the a/b pair
  // DRAIN  | waiting for pending outputs to be consumed

  dispatch_state_t         state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [CNT_WIDTH-1:0]    r_len;
  logic [CNT_WIDTH-1:0]    cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_c;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [2*DATA_WIDTH-1:0] r_pair;
  logic                    c_valid;
  logic                    pair_valid;
  logic                    r_done;
  logic                    in_fire;
  logic                    pair_take;
  logic                    c_take;
  logic                    start_acc;
  logic [15:0]             stall_cnt;
  logic                    unused_in;

  assign unused_in = ^{test_mode_i, in_strb_i};

  assign pair_take = pair_valid & a_ready_i & b_ready_i;
  assign c_take    = c_valid & c_ready_i;
  assign start_acc = ctrl_i.enable & ctrl_i.start & (state == IDLE);
  assign cnt_nxt   = r_cnt + CNT_WIDTH'(1);
  assign in_fire   = in_valid_i & in_ready_o;

  always_comb begin
    in_ready_o = 1'b0;
    if (ctrl_i.enable) begin
      unique case (state)
        LOAD_C:  in_ready_o = ~c_valid | c_ready_i;
        LOAD_A:  in_ready_o = 1'b1;
        LOAD_B:  in_ready_o = ~pair_valid | (a_ready_i & b_ready_i);
        default: in_ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_c        <= '0;
      r_a        <= '0;
      r_pair     <= '0;
      c_valid    <= 1'b0;
      pair_valid <= 1'b0;
      r_done     <= 1'b0;
    end else if (ctrl_i.clear) begin
      state      <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_c        <= '0;
      r_a        <= '0;
      r_pair     <= '0;
      c_valid    <= 1'b0;
      pair_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Output consumption is independent of enable so the engine can always drain.
      if (c_take)    c_valid    <= 1'b0;
      if (pair_take) pair_valid <= 1'b0;
      if (ctrl_i.enable) begin
        unique case (state)
          IDLE: begin
            if (ctrl_i.start) begin
              r_len <= ctrl_i.len;
              r_cnt <= '0;
              if (!ctrl_i.simple_mul)    state <= LOAD_C;
              else if (ctrl_i.len == '0) state <= DRAIN;
              else                       state <= LOAD_A;
            end
          end
          LOAD_C: begin
            if (in_fire) begin
              r_c     <= in_data_i;
              c_valid <= 1'b1;
              state   <= (r_len == '0) ? DRAIN : LOAD_A;
            end
          end
          LOAD_A: begin
            if (in_fire) begin
              r_a   <= in_data_i;
              state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (in_fire) begin
              r_pair     <= {r_a, in_data_i};
              pair_valid <= 1'b1;
              r_cnt      <= cnt_nxt;
              state      <= (cnt_nxt == r_len) ? DRAIN : LOAD_A;
            end
          end
          DRAIN: begin
            if (!pair_valid && !c_valid) begin
              state  <= IDLE;
              r_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MAC_DISPATCH_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (ctrl_i.clear || start_acc) begin
      stall_cnt <= '0;
    end else if (pair_valid && !(a_ready_i && b_ready_i) && (stall_cnt != 16'hffff)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

  assign a_data_o  = r_pair[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_data_o  = r_pair[DATA_WIDTH-1:0];
  assign a_valid_o = pair_valid;
  assign b_valid_o = pair_valid;
  assign a_strb_o  = '1;
  assign b_strb_o  = '1;
  assign c_data_o  = r_c;
  assign c_valid_o = c_valid;
  assign c_strb_o  = '1;

  assign flags_o = '{state: state, cnt: r_cnt, done: r_done, stall_cnt: stall_cnt};

endmodule
